nf_reduction_nt1: RTL and testbench

//  Parametrised N-to-1 rule reduction for the non-fast-pattern matcher.
//  - Merges NUM_IN per-packet rule streams (rule_nf_t) into one deduplicated stream.
//  - Drops repeats: against a per-input cache, and against other inputs holding the same rule in the same cycle.
//  - Emits exactly one end-of-packet "last" rule once every input presents last.
//  - Buffers output in an internal FIFO; exposes duplicate-drop and emitted-rule statistics.

---
 rtl/struct_s.sv | 12 +
 rtl/rr_arbiter.sv | 43 ++++
 rtl/unified_fifo.sv | 56 +++++
 rtl/nf_reduction_nt1.sv | 118 +++++++++++
 tb/tb_nf_reduction_nt1.sv | 374 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/struct_s.sv
// Shared rule types for the non-fast-pattern matcher datapath.
package struct_s;
    localparam int RULE_DATA_W   = 16;
    localparam int NF_RED_NUM_IN = 4;

    typedef struct packed {
        logic [RULE_DATA_W-1:0] data;
        logic                   last;
    } rule_nf_t;

    localparam int RULE_NF_W = $bits(rule_nf_t);
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts just after the last winner.
module rr_arbiter #(
    parameter int DWIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] req,
    output logic [DWIDTH-1:0] gnt
);
    localparam int PW = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] next_ptr;
    logic          found;

    // Two passes: channels above the pointer first, then wrap to the rest.
    always_comb begin
        gnt      = '0;
        next_ptr = ptr;
        found    = 1'b0;
        for (int j = 0; j < DWIDTH; j++) begin
            if (!found && req[j] && (j > int'(ptr))) begin
                gnt[j]   = 1'b1;
                next_ptr = PW'(j);
                found    = 1'b1;
            end
        end
        for (int j = 0; j < DWIDTH; j++) begin
            if (!found && req[j] && (j <= int'(ptr))) begin
                gnt[j]   = 1'b1;
                next_ptr = PW'(j);
                found    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            ptr <= PW'(DWIDTH - 1);
        else if (found)
            ptr <= next_ptr;
    end
endmodule

// File: rtl/unified_fifo.sv
// Single-clock show-ahead FIFO with optional almost-full flag.
module unified_fifo #(
    parameter int WIDTH             = 17,
    parameter int DEPTH             = 32,
    parameter int USE_ALMOST_FULL   = 1,
    parameter int ALMOST_FULL_LEVEL = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             almost_full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             full;
    logic             do_wr;
    logic             do_rd;

    assign empty       = (count == '0);
    assign full        = (count == (AW+1)'(DEPTH));
    assign almost_full = (USE_ALMOST_FULL != 0) && (count >= (AW+1)'(ALMOST_FULL_LEVEL));
    assign do_wr       = wr_en && !full;
    assign do_rd       = rd_en && !empty;
    assign rd_data     = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr)
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (do_rd)
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/nf_reduction_nt1.sv
// N-to-1 rule reduction: per-channel dedup cache, same-cycle merge, and a
// single end-of-packet "last" once every channel presents last.
module nf_reduction_nt1 import struct_s::*; #(
    parameter int NUM_IN     = NF_RED_NUM_IN,
    parameter int FIFO_DEPTH = 32,
    parameter int FULL_LEVEL = 20,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  rule_nf_t [NUM_IN-1:0] in_data,
    input  logic [NUM_IN-1:0]     in_valid,
    output logic [NUM_IN-1:0]     in_ready,
    output rule_nf_t              out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CNT_W-1:0]      stat_dup_cnt,
    output logic [CNT_W-1:0]      stat_out_cnt
);
    localparam int IW = $clog2(NUM_IN + 1);

    logic [NUM_IN-1:0]      act, last_v, hit, req, gnt, merge;
    logic [RULE_DATA_W-1:0] cache [NUM_IN];
    logic                   cache_v [NUM_IN];
    logic [RULE_DATA_W-1:0] gnt_data;
    logic                   almost_full, fifo_empty;
    logic                   sync, sync_pop, any_gnt, enq_fire;
    logic                   enq_v;
    rule_nf_t               enq_data;
    logic [RULE_NF_W-1:0]   fifo_rd;
    logic [IW-1:0]          dup_inc;
    logic [CNT_W:0]         dup_sum, out_sum;

    assign sync     = &last_v;
    assign sync_pop = sync && !almost_full;
    assign any_gnt  = |gnt;
    assign enq_fire = sync_pop || any_gnt;

    for (genvar i = 0; i < NUM_IN; i++) begin : g_ch
        assign act[i]    = in_valid[i] && !in_data[i].last;
        assign last_v[i] = in_valid[i] && in_data[i].last;
        assign hit[i]    = act[i] && cache_v[i] && (in_data[i].data == cache[i]);
        assign req[i]    = act[i] && !hit[i] && !almost_full;
        assign merge[i]  = req[i] && any_gnt && (in_data[i].data == gnt_data);

        // Last rules never touch the cache; a completed packet invalidates it.
        always_ff @(posedge clk) begin
            if (rst) begin
                cache_v[i] <= 1'b0;
                cache[i]   <= '0;
            end else if (sync_pop) begin
                cache_v[i] <= 1'b0;
            end else if (merge[i]) begin
                cache_v[i] <= 1'b1;
                cache[i]   <= in_data[i].data;
            end
        end
    end

    rr_arbiter #(.DWIDTH(NUM_IN)) u_arb (
        .clk (clk),
        .rst (rst),
        .req (req),
        .gnt (gnt)
    );

    always_comb begin
        gnt_data = '0;
        for (int j = 0; j < NUM_IN; j++)
            if (gnt[j])
                gnt_data = gnt_data | in_data[j].data;
    end

    // Channels holding last stay unpopped until everyone is at last.
    assign in_ready = sync ? {NUM_IN{!almost_full}} : (hit | merge);

    // merge includes the granted channel itself, which is not a duplicate.
    assign dup_inc = IW'($countones(hit)) + IW'($countones(merge)) - IW'(any_gnt);
    assign dup_sum = {1'b0, stat_dup_cnt} + {{(CNT_W + 1 - IW){1'b0}}, dup_inc};
    assign out_sum = {1'b0, stat_out_cnt} + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            enq_v        <= 1'b0;
            enq_data     <= '0;
            stat_dup_cnt <= '0;
            stat_out_cnt <= '0;
        end else begin
            enq_v <= enq_fire;
            if (sync_pop)
                enq_data <= in_data[0];
            else if (any_gnt)
                enq_data <= rule_nf_t'{data: gnt_data, last: 1'b0};
            stat_dup_cnt <= dup_sum[CNT_W] ? '1 : dup_sum[CNT_W-1:0];
            if (enq_fire)
                stat_out_cnt <= out_sum[CNT_W] ? '1 : out_sum[CNT_W-1:0];
        end
    end

    unified_fifo #(
        .WIDTH             (RULE_NF_W),
        .DEPTH             (FIFO_DEPTH),
        .USE_ALMOST_FULL   (1),
        .ALMOST_FULL_LEVEL (FULL_LEVEL)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (enq_v),
        .wr_data     (enq_data),
        .rd_en       (out_ready),
        .rd_data     (fifo_rd),
        .empty       (fifo_empty),
        .almost_full (almost_full)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = fifo_rd;
endmodule

// File: tb/tb_nf_reduction_nt1.sv
// Scenario bench for nf_reduction_nt1: per-channel stimulus queues, expected-output scoreboard.
module tb_nf_reduction_nt1;
    import struct_s::*;

    localparam int NUM_IN     = 4;
    localparam int FIFO_DEPTH = 32;
    localparam int FULL_LEVEL = 20;
    localparam int CNT_W      = 32;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    rule_nf_t [NUM_IN-1:0] in_data;
    logic [NUM_IN-1:0]     in_valid;
    logic [NUM_IN-1:0]     in_ready;
    rule_nf_t              out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [CNT_W-1:0]      stat_dup_cnt;
    logic [CNT_W-1:0]      stat_out_cnt;

    rule_nf_t         chq [NUM_IN][$];
    rule_nf_t         exp_q[$];
    rule_nf_t         got_q[$];
    int               pops [NUM_IN];
    logic             rst_req = 1'b1;
    logic             ordy_req = 1'b1;
    logic [NUM_IN-1:0] rdy_snap;
    logic             ovalid_snap;
    rule_nf_t         odata_snap;
    logic [CNT_W-1:0] dup_snap, outc_snap;
    int               checks = 0;
    int               errors = 0;

    nf_reduction_nt1 #(
        .NUM_IN     (NUM_IN),
        .FIFO_DEPTH (FIFO_DEPTH),
        .FULL_LEVEL (FULL_LEVEL),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .stat_dup_cnt (stat_dup_cnt),
        .stat_out_cnt (stat_out_cnt)
    );

    always #5 clk = ~clk;

    function automatic rule_nf_t mk(input logic [15:0] d, input logic l);
        rule_nf_t r;
        r.data = d;
        r.last = l;
        return r;
    endfunction

    function automatic rule_nf_t last_of(input int ch);
        return mk(16'(16'hE0 + ch), 1'b1);
    endfunction

    // Drive at negedge, sample 1ns later, retire popped entries after the posedge.
    task automatic step();
        @(negedge clk);
        rst       = rst_req;
        out_ready = ordy_req;
        for (int i = 0; i < NUM_IN; i++) begin
            if (chq[i].size() > 0) begin
                in_valid[i] = 1'b1;
                in_data[i]  = chq[i][0];
            end else begin
                in_valid[i] = 1'b0;
                in_data[i]  = '0;
            end
        end
        #1;
        rdy_snap    = in_ready;
        ovalid_snap = out_valid;
        odata_snap  = out_data;
        dup_snap    = stat_dup_cnt;
        outc_snap   = stat_out_cnt;
        if (out_valid && out_ready)
            got_q.push_back(out_data);
        @(posedge clk);
        for (int i = 0; i < NUM_IN; i++) begin
            if (rdy_snap[i] && in_valid[i]) begin
                void'(chq[i].pop_front());
                pops[i]++;
            end
        end
    endtask

    function automatic bit busy();
        for (int i = 0; i < NUM_IN; i++)
            if (chq[i].size() > 0)
                return 1'b1;
        return got_q.size() < exp_q.size();
    endfunction

    task automatic run_until_idle(input int budget, output bit timed_out);
        int n = 0;
        while (busy() && n < budget) begin
            step();
            n++;
        end
        timed_out = busy();
        repeat (4) step();
    endtask

    task automatic apply_reset();
        for (int i = 0; i < NUM_IN; i++) begin
            chq[i].delete();
            pops[i] = 0;
        end
        exp_q.delete();
        got_q.delete();
        ordy_req = 1'b1;
        rst_req  = 1'b1;
        step();
        step();
        rst_req = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        step();
        checks++;
        if (rdy_snap !== '0) begin errors++; $display("[TB] FAIL reset_in_ready: got %b, required 0", rdy_snap); end
        checks++;
        if (ovalid_snap !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b, required 0", ovalid_snap); end
        checks++;
        if (odata_snap !== '0) begin errors++; $display("[TB] FAIL reset_out_data: got %h, required 0", odata_snap); end
        checks++;
        if (dup_snap !== '0) begin errors++; $display("[TB] FAIL reset_dup_cnt: got %0d, required 0", dup_snap); end
        checks++;
        if (outc_snap !== '0) begin errors++; $display("[TB] FAIL reset_out_cnt: got %0d, required 0", outc_snap); end
    endtask

    task automatic test_merge();
        bit to;
        rule_nf_t a, e;
        apply_reset();
        for (int i = 0; i < NUM_IN; i++) begin
            chq[i].push_back(mk(16'h11, 1'b0));
            chq[i].push_back(last_of(i));
        end
        exp_q.push_back(mk(16'h11, 1'b0));
        exp_q.push_back(last_of(0));
        run_until_idle(200, to);
        checks++;
        if (to) begin errors++; $display("[TB] FAIL merge_timeout: got %0d outputs, required %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '1;
            if (got_q.size() > 0) a = got_q.pop_front();
            checks++;
            if (a !== e) begin errors++; $display("[TB] FAIL merge_out: got %h/%b, required %h/%b", a.data, a.last, e.data, e.last); end
        end
        checks++;
        if (got_q.size() != 0) begin errors++; $display("[TB] FAIL merge_extra: got %0d extra outputs, required 0", got_q.size()); end
        checks++;
        if (dup_snap !== 32'd3) begin errors++; $display("[TB] FAIL merge_dup_cnt: got %0d, required 3", dup_snap); end
        checks++;
        if (outc_snap !== 32'd2) begin errors++; $display("[TB] FAIL merge_out_cnt: got %0d, required 2", outc_snap); end
    endtask

    task automatic test_cache_drop();
        bit to;
        rule_nf_t a, e;
        apply_reset();
        chq[1].push_back(mk(16'h22, 1'b0));
        chq[1].push_back(mk(16'h22, 1'b0));
        chq[1].push_back(mk(16'h33, 1'b0));
        for (int i = 0; i < NUM_IN; i++)
            chq[i].push_back(last_of(i));
        exp_q.push_back(mk(16'h22, 1'b0));
        exp_q.push_back(mk(16'h33, 1'b0));
        exp_q.push_back(last_of(0));
        run_until_idle(200, to);
        checks++;
        if (to) begin errors++; $display("[TB] FAIL cache_timeout: got %0d outputs, required %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '1;
            if (got_q.size() > 0) a = got_q.pop_front();
            checks++;
            if (a !== e) begin errors++; $display("[TB] FAIL cache_out: got %h/%b, required %h/%b", a.data, a.last, e.data, e.last); end
        end
        checks++;
        if (got_q.size() != 0) begin errors++; $display("[TB] FAIL cache_extra: got %0d extra outputs, required 0", got_q.size()); end
        checks++;
        if (dup_snap !== 32'd1) begin errors++; $display("[TB] FAIL cache_dup_cnt: got %0d, required 1", dup_snap); end
        checks++;
        if (outc_snap !== 32'd3) begin errors++; $display("[TB] FAIL cache_out_cnt: got %0d, required 3", outc_snap); end
    endtask

    task automatic test_round_robin();
        bit to;
        rule_nf_t a, e;
        apply_reset();
        for (int p = 0; p < 4; p++) begin
            chq[0].push_back(mk(16'h05, 1'b0));
            chq[2].push_back(mk(16'h06, 1'b0));
            for (int i = 0; i < NUM_IN; i++)
                chq[i].push_back(last_of(i));
            exp_q.push_back(mk(16'h05, 1'b0));
            exp_q.push_back(mk(16'h06, 1'b0));
            exp_q.push_back(last_of(0));
        end
        run_until_idle(300, to);
        checks++;
        if (to) begin errors++; $display("[TB] FAIL rr_timeout: got %0d outputs, required %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '1;
            if (got_q.size() > 0) a = got_q.pop_front();
            checks++;
            if (a !== e) begin errors++; $display("[TB] FAIL rr_out: got %h/%b, required %h/%b", a.data, a.last, e.data, e.last); end
        end
        checks++;
        if (got_q.size() != 0) begin errors++; $display("[TB] FAIL rr_extra: got %0d extra outputs, required 0", got_q.size()); end
        checks++;
        if (dup_snap !== 32'd0) begin errors++; $display("[TB] FAIL rr_dup_cnt: got %0d, required 0", dup_snap); end
        checks++;
        if (outc_snap !== 32'd12) begin errors++; $display("[TB] FAIL rr_out_cnt: got %0d, required 12", outc_snap); end
    endtask

    task automatic test_backpressure();
        bit to;
        rule_nf_t a, e;
        apply_reset();
        ordy_req = 1'b0;
        for (int k = 0; k < 30; k++) begin
            chq[0].push_back(mk(16'(16'h100 + k), 1'b0));
            exp_q.push_back(mk(16'(16'h100 + k), 1'b0));
        end
        for (int i = 0; i < NUM_IN; i++)
            chq[i].push_back(last_of(i));
        exp_q.push_back(last_of(0));
        repeat (40) step();
        // Grants stop once the FIFO holds FULL_LEVEL; one more rule is already in flight.
        checks++;
        if (pops[0] != FULL_LEVEL + 1) begin errors++; $display("[TB] FAIL bp_accepted: got %0d, required %0d", pops[0], FULL_LEVEL + 1); end
        checks++;
        if (ovalid_snap !== 1'b1) begin errors++; $display("[TB] FAIL bp_out_valid: got %b, required 1", ovalid_snap); end
        checks++;
        if (got_q.size() != 0) begin errors++; $display("[TB] FAIL bp_stalled_out: got %0d outputs, required 0", got_q.size()); end
        ordy_req = 1'b1;
        run_until_idle(300, to);
        checks++;
        if (to) begin errors++; $display("[TB] FAIL bp_timeout: got %0d outputs, required %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '1;
            if (got_q.size() > 0) a = got_q.pop_front();
            checks++;
            if (a !== e) begin errors++; $display("[TB] FAIL bp_out: got %h/%b, required %h/%b", a.data, a.last, e.data, e.last); end
        end
        checks++;
        if (got_q.size() != 0) begin errors++; $display("[TB] FAIL bp_extra: got %0d extra outputs, required 0", got_q.size()); end
        checks++;
        if (outc_snap !== 32'd31) begin errors++; $display("[TB] FAIL bp_out_cnt: got %0d, required 31", outc_snap); end
    endtask

    task automatic test_last_hold();
        bit to;
        bit exp_rdy;
        rule_nf_t a, e;
        apply_reset();
        chq[0].push_back(mk(16'h11, 1'b0));
        chq[0].push_back(last_of(0));
        chq[0].push_back(mk(16'h11, 1'b0));
        chq[0].push_back(last_of(0));
        chq[3].push_back(mk(16'h11, 1'b0));
        exp_q.push_back(mk(16'h11, 1'b0));
        for (int k = 0; k < 9; k++) begin
            chq[3].push_back(mk(16'(16'h30 + k), 1'b0));
            exp_q.push_back(mk(16'(16'h30 + k), 1'b0));
        end
        for (int i = 0; i < NUM_IN; i++) begin
            if (i != 0) chq[i].push_back(last_of(i));
            if (i != 0) chq[i].push_back(last_of(i));
        end
        exp_q.push_back(last_of(0));
        exp_q.push_back(mk(16'h11, 1'b0));
        exp_q.push_back(last_of(0));
        // ch0 sits on last; it may only pop in the cycle ch3 also reaches last.
        for (int c = 0; c < 14; c++) begin
            step();
            if (in_valid[0] && in_data[0].last) begin
                exp_rdy = in_valid[3] && in_data[3].last;
                checks++;
                if (rdy_snap[0] !== exp_rdy) begin errors++; $display("[TB] FAIL hold_in_ready0 cycle %0d: got %b, required %b", c, rdy_snap[0], exp_rdy); end
            end
        end
        run_until_idle(200, to);
        checks++;
        if (to) begin errors++; $display("[TB] FAIL hold_timeout: got %0d outputs, required %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '1;
            if (got_q.size() > 0) a = got_q.pop_front();
            checks++;
            if (a !== e) begin errors++; $display("[TB] FAIL hold_out: got %h/%b, required %h/%b", a.data, a.last, e.data, e.last); end
        end
        checks++;
        if (got_q.size() != 0) begin errors++; $display("[TB] FAIL hold_extra: got %0d extra outputs, required 0", got_q.size()); end
        checks++;
        if (dup_snap !== 32'd1) begin errors++; $display("[TB] FAIL hold_dup_cnt: got %0d, required 1", dup_snap); end
        checks++;
        if (outc_snap !== 32'd13) begin errors++; $display("[TB] FAIL hold_out_cnt: got %0d, required 13", outc_snap); end
    endtask

    task automatic test_reset_mid_packet();
        bit to;
        rule_nf_t a, e;
        apply_reset();
        ordy_req = 1'b0;
        for (int k = 0; k < 5; k++)
            chq[0].push_back(mk(16'(16'h40 + k), 1'b0));
        repeat (8) step();
        checks++;
        if (ovalid_snap !== 1'b1) begin errors++; $display("[TB] FAIL midrst_pre_valid: got %b, required 1", ovalid_snap); end
        checks++;
        if (outc_snap !== 32'd5) begin errors++; $display("[TB] FAIL midrst_pre_out_cnt: got %0d, required 5", outc_snap); end
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        step();
        checks++;
        if (ovalid_snap !== 1'b0) begin errors++; $display("[TB] FAIL midrst_out_valid: got %b, required 0", ovalid_snap); end
        checks++;
        if (outc_snap !== '0 || dup_snap !== '0) begin errors++; $display("[TB] FAIL midrst_stats: got %0d/%0d, required 0/0", outc_snap, dup_snap); end
        got_q.delete();
        ordy_req = 1'b1;
        chq[0].push_back(mk(16'h44, 1'b0));
        for (int i = 0; i < NUM_IN; i++)
            chq[i].push_back(last_of(i));
        exp_q.push_back(mk(16'h44, 1'b0));
        exp_q.push_back(last_of(0));
        run_until_idle(200, to);
        checks++;
        if (to) begin errors++; $display("[TB] FAIL midrst_timeout: got %0d outputs, required %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '1;
            if (got_q.size() > 0) a = got_q.pop_front();
            checks++;
            if (a !== e) begin errors++; $display("[TB] FAIL midrst_out: got %h/%b, required %h/%b", a.data, a.last, e.data, e.last); end
        end
        checks++;
        if (got_q.size() != 0) begin errors++; $display("[TB] FAIL midrst_extra: got %0d extra outputs, required 0", got_q.size()); end
        checks++;
        if (outc_snap !== 32'd2) begin errors++; $display("[TB] FAIL midrst_out_cnt: got %0d, required 2", outc_snap); end
    endtask

    initial begin
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b1;
        test_reset();
        test_merge();
        test_cache_drop();
        test_round_robin();
        test_backpressure();
        test_last_hold();
        test_reset_mid_packet();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
